// File: rtl/mux2.sv
// Two-input WIDTH-bit datapath selector with combinational parity and an optional
// clocked select monitor, built only when MUX2_MONITOR_EN is defined.
module mux2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             reset,
    output logic             y_par,
    output logic             sel_q,
    output logic [CNT_W-1:0] switch_cnt
);

    // ?: keeps agreeing bits and drives X on differing bits when s is unknown.
    assign y     = s ? d1 : d0;
    assign y_par = ^y;

`ifdef MUX2_MONITOR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q      <= 1'b0;
            switch_cnt <= '0;
        end else begin
            sel_q <= s;
            // Saturate at all-ones rather than wrapping back to zero.
            if ((s != sel_q) && (switch_cnt != {CNT_W{1'b1}})) begin
                switch_cnt <= switch_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_monitor_inputs;

    assign unused_monitor_inputs = clk ^ reset;
    assign sel_q                 = 1'b0;
    assign switch_cnt            = '0;
`endif

endmodule

// File: tb/tb_mux2.sv
// Directed self-checking bench for mux2; the monitor checks follow MUX2_MONITOR_EN.
module tb_mux2;

    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        s;
    logic [7:0]  y;
    logic        clk;
    logic        reset;
    logic        y_par;
    logic        sel_q;
    logic [15:0] switch_cnt;

    logic [7:0]  y_sat;
    logic        y_par_sat;
    logic        sel_q_sat;
    logic [1:0]  switch_cnt_sat;

    logic        clk_run;
    int          n_cmp;
    int          n_bad;

    mux2 #(.WIDTH(8), .CNT_W(16)) u_dut (
        .d0(d0), .d1(d1), .s(s), .y(y),
        .clk(clk), .reset(reset),
        .y_par(y_par), .sel_q(sel_q), .switch_cnt(switch_cnt)
    );

    mux2 #(.WIDTH(8), .CNT_W(2)) u_sat (
        .d0(d0), .d1(d1), .s(s), .y(y_sat),
        .clk(clk), .reset(reset),
        .y_par(y_par_sat), .sel_q(sel_q_sat), .switch_cnt(switch_cnt_sat)
    );

    // clock/reset block: clock toggles only while clk_run is set
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sel);
        d0 = a;
        d1 = b;
        s  = sel;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // directed vectors: d0, d1, s, expected y, expected parity
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
        logic [7:0] exp_y;
        logic       exp_p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        clk_run = 1'b0;
        reset   = 1'b0;
        drive(8'h00, 8'h00, 1'b0);

        vecs[0] = '{8'h15, 8'h00, 1'b0, 8'h15, 1'b1};
        vecs[1] = '{8'h15, 8'h40, 1'b1, 8'h40, 1'b1};
        vecs[2] = '{8'h95, 8'hC0, 1'b1, 8'hC0, 1'b0};
        vecs[3] = '{8'h15, 8'h3C, 1'b0, 8'h15, 1'b1};
        vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h55, 1'b0};
        vecs[5] = '{8'hAA, 8'h57, 1'b0, 8'hAA, 1'b0};

        // clock idle: pure combinational path
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sel);
            #10;
            check_val($sformatf("y_vec%0d", i), {24'd0, y}, {24'd0, vecs[i].exp_y});
            check_val($sformatf("par_vec%0d", i), {31'd0, y_par}, {31'd0, vecs[i].exp_p});
            check_val($sformatf("ysat_vec%0d", i), {24'd0, y_sat}, {24'd0, vecs[i].exp_y});
        end

        // unknown select: agreeing bits [7:2] must still come through
        drive(8'hF0, 8'hF3, 1'bx);
        #10;
        check_val("y_sx_hi", {26'd0, y[7:2]}, {26'd0, 6'b111100});

        drive(8'h15, 8'h3C, 1'b0);
        clk_run = 1'b1;
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_sel_q", {31'd0, sel_q}, 32'd0);
        check_val("rst_cnt", {16'd0, switch_cnt}, 32'd0);
        check_val("rst_cnt_sat", {30'd0, switch_cnt_sat}, 32'd0);

`ifdef MUX2_MONITOR_EN
        for (int k = 1; k <= 5; k++) begin
            s = ~s;
            #1;
            check_val($sformatf("lag_sel_q%0d", k), {31'd0, sel_q}, {31'd0, ~s});
            tick();
            check_val($sformatf("tog_sel_q%0d", k), {31'd0, sel_q}, {31'd0, s});
            check_val($sformatf("tog_cnt%0d", k), {16'd0, switch_cnt}, k);
            check_val($sformatf("tog_y%0d", k), {24'd0, y}, {24'd0, s ? d1 : d0});
        end
        check_val("cnt_after5", {16'd0, switch_cnt}, 32'd5);
        check_val("sat_after5", {30'd0, switch_cnt_sat}, 32'd3);

        s     = ~s;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_win_cnt", {16'd0, switch_cnt}, 32'd0);
        check_val("rst_win_sel", {31'd0, sel_q}, 32'd0);
        check_val("rst_win_sat", {30'd0, switch_cnt_sat}, 32'd0);

        // saturation on the 2-bit counter instance
        s = 1'b0;
        tick();
        for (int k = 1; k <= 6; k++) begin
            d0 = 8'(8'h10 + k);
            d1 = 8'(8'hE0 + k);
            s  = ~s;
            tick();
            check_val($sformatf("sat_cnt%0d", k), {30'd0, switch_cnt_sat}, (k > 3) ? 32'd3 : k);
            check_val($sformatf("sat_y%0d", k), {24'd0, y_sat}, {24'd0, s ? 8'(8'hE0 + k) : 8'(8'h10 + k)});
        end
        tick();
        tick();
        check_val("sat_hold", {30'd0, switch_cnt_sat}, 32'd3);
        check_val("big_cnt6", {16'd0, switch_cnt}, 32'd6);
`else
        for (int k = 1; k <= 4; k++) begin
            s = ~s;
            tick();
            check_val($sformatf("off_sel_q%0d", k), {31'd0, sel_q}, 32'd0);
            check_val($sformatf("off_cnt%0d", k), {16'd0, switch_cnt}, 32'd0);
            check_val($sformatf("off_y%0d", k), {24'd0, y}, {24'd0, s ? 8'h3C : 8'h15});
        end
`endif

        // reset must not disturb the data path
        drive(8'h81, 8'h7E, 1'b1);
        reset = 1'b1;
        tick();
        check_val("rst_y", {24'd0, y}, 32'h7E);
        check_val("rst_par", {31'd0, y_par}, 32'd0);
        reset   = 1'b0;
        clk_run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
